// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit between the execute stage and a
// word-organised request/acknowledge data bus.
//
// Aligns store data and byte enables to bus lanes, extracts and extends load
// data, and reports bus faults and illegal accesses through a one-cycle
// response pulse.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   - an access crossing a bus word is split into two bus beats
//   undefined - a misaligned access faults immediately without touching the bus
module lsu_mc #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic                bus_ack,
    input  logic [XLEN-1:0]     bus_rdata,
    input  logic                bus_err
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Shift the addressed bytes down, keep len bytes and sign/zero-extend.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [2*XLEN-1:0] data2,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [XLEN-1:0] raw;
        logic [XLEN-1:0] keep;
        logic [3:0]      len;
        logic            sgn;
        raw  = XLEN'(data2 >> {off, 3'b000});
        len  = 4'd1 << size;
        keep = ~({XLEN{1'b1}} << {len, 3'b000});
        case (size)
            2'd0:    sgn = raw[7];
            2'd1:    sgn = raw[15];
            2'd2:    sgn = raw[31];
            default: sgn = raw[XLEN-1];
        endcase
        if (!uns && sgn) begin
            load_extend = (raw & keep) | ~keep;
        end else begin
            load_extend = raw & keep;
        end
    endfunction

    state_t              state_q,     state_d;
    logic [OFF_W-1:0]    off_q,       off_d;
    logic [1:0]          size_q,      size_d;
    logic                we_q,        we_d;
    logic                uns_q,       uns_d;
    logic                bus_req_q,   bus_req_d;
    logic                bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
    logic [NB-1:0]       bus_be_q,    bus_be_d;
    logic [XLEN-1:0]     bus_wdata_q, bus_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic                split_q,     split_d;
    logic [NB-1:0]       be_hi_q,     be_hi_d;
    logic [XLEN-1:0]     wdata_hi_q,  wdata_hi_d;
    logic [XLEN-1:0]     rdata0_q,    rdata0_d;
    logic [2*NB-1:0]     be2_s;
    logic [2*XLEN-1:0]   wd2_s;
`else
    logic [NB-1:0]       be1_s;
    logic [XLEN-1:0]     wd1_s;
`endif

    logic [OFF_W-1:0]    off_s;
    logic [3:0]          len_s;
    logic [NB-1:0]       len_mask_s;
    logic                misal_s;
    logic                illegal_s;
    logic [ADDR_W-1:0]   aligned_addr_s;

    // Decode the incoming request: offset, length, lane masks and data alignment.
    always_comb begin
        off_s          = req_addr[OFF_W-1:0];
        len_s          = 4'd1 << req_size;
        len_mask_s     = ~({NB{1'b1}} << len_s);
        misal_s        = (5'(off_s) + 5'(len_s)) > 5'(NB);
        illegal_s      = (req_size == 2'd3) && (XLEN != 64);
        aligned_addr_s = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef LSU_MISALIGN_SPLIT_EN
        be2_s          = {{NB{1'b0}}, len_mask_s} << off_s;
        wd2_s          = {{XLEN{1'b0}}, req_wdata} << {off_s, 3'b000};
`else
        be1_s          = len_mask_s << off_s;
        wd1_s          = req_wdata << {off_s, 3'b000};
`endif
    end

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d     = split_q;
        be_hi_d     = be_hi_q;
        wdata_hi_d  = wdata_hi_q;
        rdata0_d    = rdata0_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d  = off_s;
                    size_d = req_size;
                    we_d   = req_we;
                    uns_d  = req_unsigned;
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (illegal_s) begin
`else
                    if (illegal_s || misal_s) begin
`endif
                        // Fault without a bus access; respond next cycle.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = {XLEN{1'b0}};
                    end else begin
                        state_d    = BEAT0;
                        bus_req_d  = 1'b1;
                        bus_we_d   = req_we;
                        bus_addr_d = aligned_addr_s;
`ifdef LSU_MISALIGN_SPLIT_EN
                        bus_be_d    = be2_s[NB-1:0];
                        bus_wdata_d = wd2_s[XLEN-1:0];
                        be_hi_d     = be2_s[2*NB-1:NB];
                        wdata_hi_d  = wd2_s[2*XLEN-1:XLEN];
                        split_d     = misal_s;
`else
                        bus_be_d    = be1_s;
                        bus_wdata_d = wd1_s;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BEAT0: begin
                if (bus_ack) begin
                    if (bus_err) begin
                        state_d     = RESP;
                        bus_req_d   = 1'b0;
                        bus_we_d    = 1'b0;
                        bus_be_d    = {NB{1'b0}};
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = {XLEN{1'b0}};
`ifdef LSU_MISALIGN_SPLIT_EN
                    end else if (split_q) begin
                        // Second beat follows with no idle cycle on the bus.
                        state_d     = BEAT1;
                        bus_addr_d  = bus_addr_q + ADDR_W'(NB);
                        bus_be_d    = be_hi_q;
                        bus_wdata_d = wdata_hi_q;
                        rdata0_d    = bus_rdata;
`endif
                    end else begin
                        state_d     = RESP;
                        bus_req_d   = 1'b0;
                        bus_we_d    = 1'b0;
                        bus_be_d    = {NB{1'b0}};
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        if (we_q) begin
                            rsp_rdata_d = {XLEN{1'b0}};
                        end else begin
                            rsp_rdata_d = load_extend({{XLEN{1'b0}}, bus_rdata},
                                                      off_q, size_q, uns_q);
                        end
                    end
                end else begin
                    state_d = BEAT0;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            BEAT1: begin
                if (bus_ack) begin
                    state_d     = RESP;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_be_d    = {NB{1'b0}};
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus_err;
                    if (we_q || bus_err) begin
                        rsp_rdata_d = {XLEN{1'b0}};
                    end else begin
                        rsp_rdata_d = load_extend({bus_rdata, rdata0_q},
                                                  off_q, size_q, uns_q);
                    end
                end else begin
                    state_d = BEAT1;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            off_q       <= {OFF_W{1'b0}};
            size_q      <= 2'd0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {ADDR_W{1'b0}};
            bus_be_q    <= {NB{1'b0}};
            bus_wdata_q <= {XLEN{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {XLEN{1'b0}};
            rsp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            be_hi_q     <= {NB{1'b0}};
            wdata_hi_q  <= {XLEN{1'b0}};
            rdata0_q    <= {XLEN{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= split_d;
            be_hi_q     <= be_hi_d;
            wdata_hi_q  <= wdata_hi_d;
            rdata0_q    <= rdata0_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
Multi-cycle, parametrised load/store unit that sits between the execute stage and a word-organised data bus with a request/acknowledge handshake.
- Aligns store data and generates byte enables.
- Extracts and sign/zero-extends load data.
- Holds the pipeline via a ready/valid request interface.
- Supports wait-stated memory and bus errors.
- Optionally splits misaligned accesses into two bus beats.

Parameters:
XLEN, 32, data width; 32 or 64. NB = XLEN/8 bytes per bus word.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  access request from pipeline
req_ready  out  1  LSU can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when XLEN=64)
req_unsigned  in  1  zero-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  extended load data (0 for stores and errors)
rsp_err  out  1  access faulted; qualified by rsp_valid
bus_req  out  1  bus transaction request, held until bus_ack
bus_we  out  1  bus write
bus_addr  out  ADDR_W  word-aligned bus address (low log2(NB) bits zero)
bus_be  out  NB  byte enables
bus_wdata  out  XLEN  lane-aligned write data
bus_ack  in  1  transaction complete; bus_rdata/bus_err valid this cycle
bus_rdata  in  XLEN  read data
bus_err  in  1  bus fault

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, req_ready=1 after reset, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. All outputs except req_ready are registered.
- Request capture: accept when req_valid && req_ready. Register addr, size, we, unsigned and wdata.
- Derived values: off = addr mod NB; len = 1<<size.
- Misaligned condition: off+len > NB.
- Illegal size: size=3 with XLEN=32. Completes with rsp_err=1 and no bus access.
- Byte-enable mask: 2*NB bits, ((1<<len)-1)<<off. Low NB bits go to beat0, high NB bits to beat1.
- Write data: 2*XLEN-bit value, wdata<<(off*8). Low half goes to beat0, high half to beat1.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE → BEAT0 on accept. bus_req rises the cycle after accept, with beat0 addr = addr with low bits cleared.
- BEAT0:
  - bus_ack with bus_err → RESP, err=1, beat1 skipped.
  - bus_ack with split access → BEAT1. bus_addr = beat0 addr + NB. bus_req stays high, with no idle cycle between beats.
  - bus_ack otherwise → RESP.
- BEAT1: on bus_ack → RESP; err = bus_err.
- bus_req drops the cycle after the final ack.
- Read capture: bus_rdata is captured on each read ack.
- Load result: {beat1_data, beat0_data} >> (off*8), truncated to len bytes, then sign-extended (req_unsigned=0) or zero-extended. For an unsplit access, beat1_data = 0.
- RESP: rsp_valid=1 for exactly one cycle, then → IDLE. req_ready returns high in the same cycle.
- Latency, aligned and zero wait: accept T, bus_req T+1, ack T+1, rsp_valid T+2.
- No back-to-back overlap: the next request is accepted only in IDLE.
- Ack outside BEAT0/BEAT1 is ignored.
- Reset mid-operation: next edge → IDLE, bus_req=0, no rsp_valid. A pending ack arriving later is ignored.

Optional Feature:
Macro LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split into BEAT0+BEAT1 as above.
- Undefined: a misaligned access makes no bus request. BEAT1 state logic is removed. The FSM goes IDLE → RESP directly, rsp_valid at T+1, rsp_err=1, rsp_rdata=0.

Test Plan (XLEN=32):
1. LW 0x100, bus_rdata 0xDEADBEEF, ack after 2 wait cycles → bus_addr 0x100, bus_be 1111; rsp_rdata 0xDEADBEEF, rsp_err 0; rsp_valid exactly 1 cycle after ack.
2. SB 0x203, wdata 0x000000A5 → bus_we 1, bus_addr 0x200, bus_be 1000, bus_wdata 0xA5000000; rsp_rdata 0.
3. LH 0x102, bus_rdata 0x80017777 → rsp_rdata 0xFFFF8001. LHU same stimulus → 0x00008001.
4. LW 0x103 with macro defined:
   - beat0: addr 0x100, be 1000, rdata 0x11223344.
   - beat1: addr 0x104, be 0111, rdata 0x55667788.
   - Response: rsp_rdata 0x66778811.
   With macro undefined: no bus_req, rsp_err 1 at T+1.
5. SW 0x0FE split (macro defined), bus_err on beat0 → no beat1 request; rsp_err 1.
6. rst asserted while bus_req waits for ack → bus_req 0 and req_ready 1 next cycle; late bus_ack produces no rsp_valid.
